mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Sequencer and arbiter for the single shared word-wide memory of the multicycle datapath. Two requesters share the memory: the instruction-fetch path and the load/store path. The block owns the memory address, write-enable and write-data lines, inserts the memory read wait state, and implements byte/halfword stores as read-modify-write. The main control FSM issues requests and waits for the acknowledge instead of counting memory cycles itself.

## Interface
- WAIT_CYCLES, 1, clock edges of memory read latency beyond the first; READ lasts WAIT_CYCLES+1 cycles (minimum 0).
- clock  in  1  system clock, all state on rising edge
- reset  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request, level, held until if_ack
- if_addr  in  32  fetch byte address
- if_ack  out  1  one-cycle pulse: fetch complete
- if_err  out  1  pulses with if_ack when if_addr[1:0]≠0
- if_rdata  out  32  fetched word, valid from if_ack, held until next fetch ack
- d_req  in  1  data request, level, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  00 word, 01 half, 10 byte, 11 reserved
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, right-justified for half/byte
- d_ack  out  1  one-cycle pulse: data access complete
- d_err  out  1  pulses with d_ack on misalignment or reserved size
- d_rdata  out  32  load result, zero-extended, held until next data ack
- mem_addr  out  32  word address to memory (low two bits always 0)
- mem_wr  out  1  memory write enable
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, READ, WRITE, DONE, ERR.
- IDLE: if d_req, grant data; else if if_req, grant fetch. Fixed priority data > fetch. On grant latch requester, address, size, we, wdata.
- Alignment check at grant: word needs addr[1:0]=0, half needs addr[0]=0, size 11 always error, fetch always word. Error → ERR (no memory cycle, mem_wr never asserted).
- Fetch, load, sub-word store: IDLE → READ. mem_addr = {addr[31:2],2'b00} held constant. READ lasts WAIT_CYCLES+1 cycles; mem_rdata sampled on the final READ edge.
- After READ: fetch/load → DONE; half/byte store → WRITE with merged word.
- Word store: IDLE → WRITE directly; mem_wdata = d_wdata.
- Merge (little-endian, lane 0 = bits 7:0): byte replaces lane addr[1:0] with wdata[7:0]; half replaces bits 15:0 (addr[1]=0) or 31:16 (addr[1]=1) with wdata[15:0]; other lanes from read word.
- Load extraction: byte → {24'b0, lane addr[1:0]}; half → {16'b0, selected half}; word unchanged.
- WRITE: mem_wr=1 for exactly this one cycle → DONE.
- DONE: ack of granted requester pulses; if_rdata/d_rdata updated on entry; → IDLE.
- ERR: ack and err of granted requester pulse; → IDLE. rdata unchanged.
- Requester must deassert req in the cycle after ack; req still high in IDLE is a new request.

## Timing
- Grant edge = T0 (IDLE with req). Defaults WAIT_CYCLES=1:
- Fetch/load: READ T1–T2, DONE T3, ack at T3.
- Word store: WRITE T1, ack at T2.
- Sub-word store: READ T1–T2, WRITE T3, ack at T4.
- Error: ack+err at T1.
- General read ack at T(WAIT_CYCLES+2).
- Next grant at earliest one cycle after ack (IDLE).
- mem_wr, acks, errs decoded from registered state only; no combinational path req → mem_wr.
- Reset values: state IDLE, mem_addr 0, mem_wr 0, mem_wdata 0, if_ack/d_ack/if_err/d_err 0, if_rdata 0, d_rdata 0, busy 0.
- Reset mid-transaction: abort; from the cycle after the reset edge mem_wr=0, no ack for the aborted access, state IDLE; a half-done RMW leaves memory unmodified.
- Requests arriving while busy are not sampled until IDLE.

## Test plan
- Reset, mem[0x04]=0xDEADBEEF, if_req addr 0x04 at T0 → if_ack at T3, if_rdata=0xDEADBEEF, mem_addr=0x04 T1–T2, mem_wr never 1.
- mem[0x100]=0x11223344, byte store d_wdata=0x000000AB addr 0x103 → mem_wr only at T3 with mem_wdata=0xAB223344, d_ack T4.
- mem[0x100]=0x11223344, half load addr 0x102 → d_rdata=0x00001122 at T3; byte load addr 0x101 → 0x00000033.
- if_req and d_req (word load 0x100) both high at T0 → d_ack T3, IDLE T4, fetch granted T4, if_ack T7.
- Word store addr 0x101; half load d_size=11 → d_ack+d_err at T1, mem_wr stays 0, d_rdata unchanged.
- Byte store started, reset asserted at T2 (in READ) → no mem_wr, no d_ack, busy=0 and all outputs at reset values the cycle after.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Sequencer and arbiter for the single shared word-wide memory. The fetch
// path and the load/store path both request memory through this block. It
// owns the memory address, write enable and write data. It inserts the read
// wait state and performs byte/halfword stores as read-modify-write.
//
// Ports
//   clock, reset           system clock; synchronous active-high reset
//   if_req/if_addr         fetch request (level) and byte address
//   if_ack/if_err/if_rdata fetch completion pulse, misalignment flag, word
//   d_req/d_we/d_size      data request (level), store flag, size
//                          (00 word, 01 half, 10 byte, 11 reserved)
//   d_addr/d_wdata         data byte address, right-justified store data
//   d_ack/d_err/d_rdata    data completion pulse, error flag, zero-extended load
//   mem_addr/mem_wr        word address to memory (bits 1:0 always 0), write enable
//   mem_wdata/mem_rdata    memory write data, memory read data
//   busy                   high in every state except IDLE
module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic        if_err,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES);

  typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ERR} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // Attributes of the granted access, latched at grant.
  logic          sel_data;
  logic          cur_we;
  logic [1:0]    cur_size;
  logic [1:0]    cur_off;
  logic [15:0]   cur_wdata;

  // Grant decode from the live request inputs; only feeds registers.
  logic          g_data;
  logic [31:0]   g_addr;
  logic [1:0]    g_size;
  logic          g_we;
  logic          g_err;
  logic          g_word_store;

  always_comb begin
    g_data = d_req;
    g_addr = d_req ? d_addr : if_addr;
    g_size = d_req ? d_size : 2'b00;
    g_we   = d_req & d_we;
    case (g_size)
      2'b00:   g_err = (g_addr[1:0] != 2'b00);
      2'b01:   g_err = g_addr[0];
      2'b10:   g_err = 1'b0;
      default: g_err = 1'b1;
    endcase
    g_word_store = g_we && (g_size == 2'b00);
  end

  // Lane merge for sub-word stores and lane extraction for loads, both
  // working on the word currently presented by memory.
  logic [31:0] merged;
  logic [31:0] extracted;

  always_comb begin
    merged    = mem_rdata;
    extracted = mem_rdata;
    case (cur_size)
      2'b01: begin
        merged[{cur_off[1], 4'b0000} +: 16] = cur_wdata;
        extracted = {16'b0, mem_rdata[{cur_off[1], 4'b0000} +: 16]};
      end
      2'b10: begin
        merged[{cur_off, 3'b000} +: 8] = cur_wdata[7:0];
        extracted = {24'b0, mem_rdata[{cur_off, 3'b000} +: 8]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sel_data  <= 1'b0;
      cur_we    <= 1'b0;
      cur_size  <= '0;
      cur_off   <= '0;
      cur_wdata <= '0;
      mem_addr  <= '0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      if_err    <= 1'b0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      busy      <= 1'b0;
    end else begin
      // Pulsed outputs default low; each is set for exactly the one state
      // entered at this edge.
      mem_wr <= 1'b0;
      if_ack <= 1'b0;
      if_err <= 1'b0;
      d_ack  <= 1'b0;
      d_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (d_req || if_req) begin
            sel_data  <= g_data;
            cur_we    <= g_we;
            cur_size  <= g_size;
            cur_off   <= g_addr[1:0];
            cur_wdata <= d_wdata[15:0];
            cnt       <= '0;
            busy      <= 1'b1;
            if (g_err) begin
              state <= ERR;
              if (g_data) begin
                d_ack <= 1'b1;
                d_err <= 1'b1;
              end else begin
                if_ack <= 1'b1;
                if_err <= 1'b1;
              end
            end else begin
              mem_addr <= {g_addr[31:2], 2'b00};
              if (g_word_store) begin
                state     <= WRITE;
                mem_wr    <= 1'b1;
                mem_wdata <= d_wdata;
              end else begin
                state <= READ;
              end
            end
          end
        end
        READ: begin
          if (cnt == LAST) begin
            if (cur_we) begin
              state     <= WRITE;
              mem_wr    <= 1'b1;
              mem_wdata <= merged;
            end else begin
              state <= DONE;
              if (sel_data) begin
                d_ack   <= 1'b1;
                d_rdata <= extracted;
              end else begin
                if_ack   <= 1'b1;
                if_rdata <= extracted;
              end
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WRITE: begin
          // Only the data path can store.
          state <= DONE;
          d_ack <= 1'b1;
        end
        DONE, ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
// Directed and randomized bench for mem_access_ctrl. A word-addressed memory
// (256 words) sits behind the DUT; a separate reference copy plus arithmetic
// on byte lanes gives the expected latency, error, write word and load data.
module tb_mem_access_ctrl;

  localparam int unsigned WAIT = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic        if_err;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic        d_err;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  mem_access_ctrl #(.WAIT_CYCLES(WAIT)) dut (
    .clock     (clock),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_err    (if_err),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_size    (d_size),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_err     (d_err),
    .d_rdata   (d_rdata),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic        poke_en;
  logic [7:0]  poke_idx;
  logic [31:0] poke_val;

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clock) begin
    if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
    else if (poke_en) mem[poke_idx] <= poke_val;
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_d_rdata;
  bit          d_known;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] idx, input logic [31:0] val);
    @(negedge clock);
    poke_idx     = idx;
    poke_val     = val;
    poke_en      = 1'b1;
    ref_mem[idx] = val;
    @(negedge clock);
    poke_en = 1'b0;
  endtask

  // One complete access from request to the IDLE cycle after its ack.
  task automatic access(input bit dat, input bit we, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] wd);
    logic [7:0]  idx;
    int unsigned off, sh, exp_lat, lat, nwr, wr_cycle;
    bit          err, rd, wr, got_err, other_ack, t1_busy;
    logic [31:0] old, mask, exp_word, exp_load, seen_wdata, seen_waddr, t1_addr;

    idx = addr[9:2];
    off = 32'(addr[1:0]);
    old = ref_mem[idx];
    if (!dat) err = (off != 0);
    else begin
      case (sz)
        2'b00:   err = (off != 0);
        2'b01:   err = (off % 2) != 0;
        2'b10:   err = 1'b0;
        default: err = 1'b1;
      endcase
    end
    wr      = !err && dat && we;
    rd      = !err && !(wr && sz == 2'b00);
    exp_lat = err ? 1 : ((rd ? WAIT + 1 : 0) + (wr ? 1 : 0) + 1);

    exp_word = old;
    exp_load = old;
    if (dat && sz == 2'b01) begin
      sh       = 16 * (off / 2);
      mask     = 32'h0000FFFF << sh;
      exp_word = (old & ~mask) | ((wd & 32'h0000FFFF) << sh);
      exp_load = (old >> sh) & 32'h0000FFFF;
    end else if (dat && sz == 2'b10) begin
      sh       = 8 * off;
      mask     = 32'h000000FF << sh;
      exp_word = (old & ~mask) | ((wd & 32'h000000FF) << sh);
      exp_load = (old >> sh) & 32'h000000FF;
    end else if (dat && sz == 2'b00) begin
      exp_word = wd;
    end

    @(negedge clock);
    if (dat) begin
      d_req = 1'b1; d_we = we; d_size = sz; d_addr = addr; d_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end

    lat = 0; nwr = 0; wr_cycle = 0; got_err = 1'b0; other_ack = 1'b0;
    t1_busy = 1'b0; t1_addr = '0; seen_wdata = '0; seen_waddr = '0;
    for (int unsigned n = 1; n <= 20 && lat == 0; n++) begin
      @(negedge clock);
      if (n == 1) begin
        t1_addr = mem_addr;
        t1_busy = busy;
      end
      if (mem_wr) begin
        nwr++;
        wr_cycle   = n;
        seen_wdata = mem_wdata;
        seen_waddr = mem_addr;
      end
      if (dat ? d_ack : if_ack) begin
        lat       = n;
        got_err   = dat ? d_err : if_err;
        other_ack = dat ? if_ack : d_ack;
        d_req  = 1'b0;
        if_req = 1'b0;
      end
    end
    d_req  = 1'b0;
    if_req = 1'b0;

    check("ack_latency", lat, exp_lat);
    check("err_flag", 32'(got_err), 32'(err));
    check("other_ack", 32'(other_ack), 32'd0);
    check("busy_t1", 32'(t1_busy), 32'd1);
    check("write_count", nwr, wr ? 32'd1 : 32'd0);
    if (!err) check("mem_addr_t1", t1_addr, {addr[31:2], 2'b00});
    if (wr) begin
      check("write_cycle", wr_cycle, exp_lat - 1);
      check("write_addr", seen_waddr, {addr[31:2], 2'b00});
      check("mem_wdata", seen_wdata, exp_word);
      ref_mem[idx] = exp_word;
    end

    if (!dat) begin
      if (!err) exp_if_rdata = old;
      check("if_rdata", if_rdata, exp_if_rdata);
    end else if (err) begin
      if (d_known) check("d_rdata_held", d_rdata, exp_d_rdata);
    end else if (!we) begin
      exp_d_rdata = exp_load;
      d_known     = 1'b1;
      check("d_rdata", d_rdata, exp_d_rdata);
    end else begin
      d_known = 1'b0;
    end

    @(negedge clock);
    check("busy_idle", 32'(busy), 32'd0);
    check("mem_word", mem[idx], ref_mem[idx]);
  endtask

  initial begin
    int unsigned dl, il;
    logic [31:0] b4, a5;
    bit          rw_seen, ra_seen;
    bit          r_dat, r_we;
    logic [1:0]  r_sz;
    logic [31:0] r_addr, r_wd;

    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = '0; d_addr = '0; d_wdata = '0;
    poke_en = 1'b0; poke_idx = '0; poke_val = '0;
    exp_if_rdata = '0; exp_d_rdata = '0; d_known = 1'b1;

    for (int unsigned i = 0; i < 256; i++) poke(8'(i), $urandom);

    @(negedge clock);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_if_ack", 32'(if_ack), 32'd0);
    check("rst_d_ack", 32'(d_ack), 32'd0);
    check("rst_if_err", 32'(if_err), 32'd0);
    check("rst_d_err", 32'(d_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    reset = 1'b0;

    // Fetch, sub-word store, sub-word loads.
    poke(8'h01, 32'hDEADBEEF);
    access(1'b0, 1'b0, 2'b00, 32'h0000_0004, 32'h0);
    check("fetch_word", if_rdata, 32'hDEADBEEF);
    poke(8'h40, 32'h11223344);
    access(1'b1, 1'b1, 2'b10, 32'h0000_0103, 32'h0000_00AB);
    check("byte_store_word", ref_mem[8'h40], 32'hAB223344);
    poke(8'h40, 32'h11223344);
    access(1'b1, 1'b0, 2'b01, 32'h0000_0102, 32'h0);
    check("half_load", d_rdata, 32'h00001122);
    access(1'b1, 1'b0, 2'b10, 32'h0000_0101, 32'h0);
    check("byte_load", d_rdata, 32'h00000033);

    // Simultaneous requests: data wins, fetch follows after the IDLE cycle.
    @(negedge clock);
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b00; d_addr = 32'h0000_0100;
    if_req = 1'b1; if_addr = 32'h0000_0004;
    dl = 0; il = 0; b4 = 32'd1; a5 = '0;
    for (int unsigned n = 1; n <= 30 && il == 0; n++) begin
      @(negedge clock);
      if (n == 4) b4 = 32'(busy);
      if (n == 5) a5 = mem_addr;
      if (d_ack && dl == 0) begin
        dl = n;
        d_req = 1'b0;
      end
      if (if_ack) begin
        il = n;
        if_req = 1'b0;
      end
    end
    d_req = 1'b0; if_req = 1'b0;
    check("prio_d_ack", dl, WAIT + 2);
    check("prio_if_ack", il, 2 * (WAIT + 2) + 1);
    check("prio_idle_t4", b4, 32'd0);
    check("prio_fetch_addr", a5, 32'h0000_0004);
    check("prio_d_rdata", d_rdata, ref_mem[8'h40]);
    check("prio_if_rdata", if_rdata, ref_mem[8'h01]);
    exp_d_rdata = ref_mem[8'h40]; d_known = 1'b1;
    exp_if_rdata = ref_mem[8'h01];
    @(negedge clock);

    // Errors: misaligned word store, reserved size.
    access(1'b1, 1'b1, 2'b00, 32'h0000_0101, 32'h12345678);
    access(1'b1, 1'b0, 2'b11, 32'h0000_0100, 32'h0);
    access(1'b0, 1'b0, 2'b00, 32'h0000_0006, 32'h0);

    // Randomized mix.
    for (int unsigned i = 0; i < 80; i++) begin
      r_dat  = ($urandom_range(0, 2) != 0);
      r_we   = 1'($urandom_range(0, 1));
      r_sz   = 2'($urandom_range(0, 3));
      r_addr = {22'b0, 8'($urandom), 2'($urandom)};
      r_wd   = $urandom;
      access(r_dat, r_we, r_sz, r_addr, r_wd);
    end

    // Reset in the middle of a read-modify-write.
    @(negedge clock);
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 32'h0000_0103; d_wdata = 32'h0000_00CD;
    rw_seen = 1'b0; ra_seen = 1'b0;
    @(negedge clock);
    rw_seen |= mem_wr; ra_seen |= d_ack;
    @(negedge clock);
    rw_seen |= mem_wr; ra_seen |= d_ack;
    reset = 1'b1;
    @(negedge clock);
    check("abort_mem_wr", 32'(mem_wr), 32'd0);
    check("abort_d_ack", 32'(d_ack), 32'd0);
    check("abort_d_err", 32'(d_err), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_mem_addr", mem_addr, 32'd0);
    check("abort_mem_wdata", mem_wdata, 32'd0);
    check("abort_d_rdata", d_rdata, 32'd0);
    check("abort_if_rdata", if_rdata, 32'd0);
    reset = 1'b0;
    d_req = 1'b0;
    for (int unsigned n = 0; n < 4; n++) begin
      @(negedge clock);
      rw_seen |= mem_wr; ra_seen |= d_ack;
    end
    check("abort_no_write", 32'(rw_seen), 32'd0);
    check("abort_no_ack", 32'(ra_seen), 32'd0);
    check("abort_mem_intact", mem[8'h40], ref_mem[8'h40]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
